// File: rtl/storage_fifo_pkg.sv
// -----------------------------------------------------------------------------
// storage_fifo_pkg
//   Shared helpers and types for the storage FIFO controller slice.
//   - addr_w(depth) : width of a storage address for a given depth
//   - cnt_w(depth)  : width of an occupancy count able to hold 0..depth
//   - fifo_state_e  : occupancy classification used for assertion naming
// -----------------------------------------------------------------------------
package storage_fifo_pkg;

    typedef enum logic [1:0] {
        IDLE_EMPTY,
        PARTIAL,
        FULL
    } fifo_state_e;

    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/storage_fifo_ptr.sv
// -----------------------------------------------------------------------------
// storage_fifo_ptr
//   Circular address pointer for the storage array. Advances by one on inc and
//   wraps from DEPTH-1 to 0 by explicit compare, so DEPTH need not be a power
//   of two and addresses >= DEPTH are never produced.
// Ports:
//   clk   in  1       clock
//   rst_n in  1       asynchronous reset, active low (pointer -> 0)
//   inc   in  1       advance the pointer this cycle
//   ptr   out addr_w  current pointer value
// -----------------------------------------------------------------------------
module storage_fifo_ptr
    import storage_fifo_pkg::*;
#(
    parameter int DEPTH = 512
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      inc,
    output logic [addr_w(DEPTH)-1:0]  ptr
);

    localparam int               PTR_W = addr_w(DEPTH);
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0] r_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (inc) begin
            r_ptr <= (r_ptr == LAST) ? '0 : r_ptr + PTR_W'(1);
        end
    end

    assign ptr = r_ptr;

endmodule

// File: rtl/storage_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// storage_fifo_ctrl
//   Valid/ready show-ahead FIFO controller driving an external flip-flop
//   storage array. Owns the write/read pointers, the occupancy count and the
//   full/empty flags; the storage array holds the data.
//
//   Handshake: a transfer happens on a rising clk edge when valid and ready are
//   both high in the preceding cycle (push = in_valid & in_ready,
//   pop = out_valid & out_ready). The producer holds in_data stable while
//   in_valid is high and in_ready is low. in_ready never depends on out_ready,
//   so there is no pass-through when full and no bypass when empty.
//
//   Optional feature macro: STORAGE_FIFO_LEVEL_EN adds parameter AF_LVL and the
//   level / almost_full outputs. Without it the core behaviour is identical.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid/in_ready/in_data   producer side
//   out_valid/out_ready/out_data consumer side (out_data = st_rd_data)
//   level, almost_full          occupancy and threshold flag (macro only)
//   st_wr_en/st_wr_addrs/st_wr_data storage write port
//   st_rd_en/st_rd_addrs/st_rd_data storage read port (read is combinational)
// -----------------------------------------------------------------------------
module storage_fifo_ctrl
    import storage_fifo_pkg::*;
#(
    parameter int WIDTH  = 1024,
    parameter int DEPTH  = 512
`ifdef STORAGE_FIFO_LEVEL_EN
    ,
    parameter int AF_LVL = DEPTH - 2
`endif
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
`ifdef STORAGE_FIFO_LEVEL_EN
    output logic [cnt_w(DEPTH)-1:0]   level,
    output logic                      almost_full,
`endif
    output logic                      st_wr_en,
    output logic [addr_w(DEPTH)-1:0]  st_wr_addrs,
    output logic [WIDTH-1:0]          st_wr_data,
    output logic                      st_rd_en,
    output logic [addr_w(DEPTH)-1:0]  st_rd_addrs,
    input  logic [WIDTH-1:0]          st_rd_data
);

    localparam int CNT_W = cnt_w(DEPTH);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    fifo_state_e      w_state;

    // Flags come straight from the count register, never from pointer compare.
    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_empty   = (r_count == '0);

    assign in_ready  = !w_full;
    assign out_valid = !w_empty;
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_nxt;
        end
    end

    storage_fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_push),
        .ptr   (st_wr_addrs)
    );

    storage_fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_pop),
        .ptr   (st_rd_addrs)
    );

    assign st_wr_en   = w_push;
    assign st_wr_data = in_data;
    assign st_rd_en   = !w_empty;
    assign out_data   = st_rd_data;

`ifdef STORAGE_FIFO_LEVEL_EN
    logic r_almost_full;

    // Computed from the next count so the flag lands in the same cycle as level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_almost_full <= 1'b0;
        end else begin
            r_almost_full <= (w_count_nxt >= CNT_W'(AF_LVL));
        end
    end

    assign level       = r_count;
    assign almost_full = r_almost_full;
`endif

    // Occupancy class, used to name the protocol checks below.
    always_comb begin
        w_state = PARTIAL;
        if (w_empty)     w_state = IDLE_EMPTY;
        else if (w_full) w_state = FULL;
    end

    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        (w_state == FULL) |-> !w_push);

    a_no_pop_when_empty: assert property (@(posedge clk) disable iff (!rst_n)
        (w_state == IDLE_EMPTY) |-> !w_pop);

    a_count_in_range: assert property (@(posedge clk) disable iff (!rst_n)
        r_count <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_storage_fifo_ctrl.sv
`timescale 1ns/1ps
module tb_storage_fifo_ctrl;

    localparam int W  = 8;
    localparam int D0 = 4;
    localparam int D1 = 5;
    localparam int AF = 3;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // instance 0: DEPTH=4
    logic         in_valid0, in_ready0, out_valid0, out_ready0;
    logic [W-1:0] in_data0, out_data0, wr_data0, rd_data0;
    logic         wr_en0, rd_en0;
    logic [1:0]   wr_addr0, rd_addr0;
    // instance 1: DEPTH=5
    logic         in_valid1, in_ready1, out_valid1, out_ready1;
    logic [W-1:0] in_data1, out_data1, wr_data1, rd_data1;
    logic         wr_en1, rd_en1;
    logic [2:0]   wr_addr1, rd_addr1;
`ifdef STORAGE_FIFO_LEVEL_EN
    logic [2:0]   level0, level1;
    logic         af0, af1;
`endif

    storage_fifo_ctrl #(
        .WIDTH(W), .DEPTH(D0)
`ifdef STORAGE_FIFO_LEVEL_EN
        , .AF_LVL(AF)
`endif
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
`ifdef STORAGE_FIFO_LEVEL_EN
        .level(level0), .almost_full(af0),
`endif
        .st_wr_en(wr_en0), .st_wr_addrs(wr_addr0), .st_wr_data(wr_data0),
        .st_rd_en(rd_en0), .st_rd_addrs(rd_addr0), .st_rd_data(rd_data0)
    );

    storage_fifo_ctrl #(
        .WIDTH(W), .DEPTH(D1)
`ifdef STORAGE_FIFO_LEVEL_EN
        , .AF_LVL(AF)
`endif
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
`ifdef STORAGE_FIFO_LEVEL_EN
        .level(level1), .almost_full(af1),
`endif
        .st_wr_en(wr_en1), .st_wr_addrs(wr_addr1), .st_wr_data(wr_data1),
        .st_rd_en(rd_en1), .st_rd_addrs(rd_addr1), .st_rd_data(rd_data1)
    );

    // storage array models (flip-flop arrays, combinational read)
    logic [W-1:0] mem0 [D0];
    logic [W-1:0] mem1 [D1];
    always @(posedge clk) if (wr_en0) mem0[wr_addr0] <= wr_data0;
    always @(posedge clk) if (wr_en1) mem1[wr_addr1] <= wr_data1;
    assign rd_data0 = mem0[rd_addr0];
    assign rd_data1 = mem1[rd_addr1];

    // reference model: queue contents plus lifetime push/pop totals
    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];
    int unsigned  n_push0, n_pop0, n_push1, n_pop1;
    int           n_assert, n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        in_valid0 = 1'b0; in_data0 = '0; out_ready0 = 1'b0;
        in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b0;
    endtask

    // Applies reset, checks the reset values on both instances while reset is
    // held, releases on a falling edge and empties the model.
    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        #1;
        chk("rst_in_ready0",  32'(in_ready0),  32'd1);
        chk("rst_out_valid0", 32'(out_valid0), 32'd0);
        chk("rst_wr_en0",     32'(wr_en0),     32'd0);
        chk("rst_rd_en0",     32'(rd_en0),     32'd0);
        chk("rst_in_ready1",  32'(in_ready1),  32'd1);
        chk("rst_out_valid1", 32'(out_valid1), 32'd0);
`ifdef STORAGE_FIFO_LEVEL_EN
        chk("rst_level0", 32'(level0), 32'd0);
        chk("rst_af0",    32'(af0),    32'd0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q0.delete(); exp_q1.delete();
        n_push0 = 0; n_pop0 = 0; n_push1 = 0; n_pop1 = 0;
    endtask

    // One clock cycle on instance sel: drive at the falling edge, check all
    // outputs against the model, then advance the model at the rising edge.
    task automatic cycle(input int sel, input logic v, input logic [W-1:0] d, input logic r);
        int   sz;
        logic push, pop;
        if (sel == 0) begin
            in_valid0 = v; in_data0 = d; out_ready0 = r;
        end else begin
            in_valid1 = v; in_data1 = d; out_ready1 = r;
        end
        #1;
        if (sel == 0) begin
            sz   = exp_q0.size();
            push = v && (sz < D0);
            pop  = r && (sz > 0);
            chk("in_ready0",  32'(in_ready0),  32'(sz < D0));
            chk("out_valid0", 32'(out_valid0), 32'(sz > 0));
            chk("st_wr_en0",  32'(wr_en0),     32'(push));
            chk("st_rd_en0",  32'(rd_en0),     32'(sz > 0));
            if (push) begin
                chk("wr_addr0", 32'(wr_addr0), n_push0 % D0);
                chk("wr_data0", 32'(wr_data0), 32'(d));
            end
            if (sz > 0) begin
                chk("rd_addr0",  32'(rd_addr0),  n_pop0 % D0);
                chk("out_data0", 32'(out_data0), 32'(exp_q0[0]));
            end
`ifdef STORAGE_FIFO_LEVEL_EN
            chk("level0", 32'(level0), 32'(sz));
            chk("af0",    32'(af0),    32'(sz >= AF));
`endif
        end else begin
            sz   = exp_q1.size();
            push = v && (sz < D1);
            pop  = r && (sz > 0);
            chk("in_ready1",  32'(in_ready1),  32'(sz < D1));
            chk("out_valid1", 32'(out_valid1), 32'(sz > 0));
            chk("st_wr_en1",  32'(wr_en1),     32'(push));
            chk("wr_range1",  32'(wr_addr1 < 3'd5), 32'd1);
            chk("rd_range1",  32'(rd_addr1 < 3'd5), 32'd1);
            if (push) chk("wr_addr1", 32'(wr_addr1), n_push1 % D1);
            if (sz > 0) begin
                chk("rd_addr1",  32'(rd_addr1),  n_pop1 % D1);
                chk("out_data1", 32'(out_data1), 32'(exp_q1[0]));
            end
`ifdef STORAGE_FIFO_LEVEL_EN
            chk("level1", 32'(level1), 32'(sz));
            chk("af1",    32'(af1),    32'(sz >= AF));
`endif
        end
        @(posedge clk);
        if (sel == 0) begin
            if (pop)  begin void'(exp_q0.pop_front()); n_pop0++; end
            if (push) begin exp_q0.push_back(d); n_push0++; end
        end else begin
            if (pop)  begin void'(exp_q1.pop_front()); n_pop1++; end
            if (push) begin exp_q1.push_back(d); n_push1++; end
        end
        @(negedge clk);
    endtask

    initial begin
        n_assert = 0; n_fail = 0;
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        do_reset();

        // single word: visible the cycle after the push
        cycle(0, 1'b1, 8'hA1, 1'b0);
        cycle(0, 1'b0, 8'h00, 1'b0);
        cycle(0, 1'b0, 8'h00, 1'b1);
        cycle(0, 1'b0, 8'h00, 1'b0);

        // fill to full, then a refused fifth word
        do_reset();
        for (int i = 1; i <= 4; i++) cycle(0, 1'b1, 8'(i), 1'b0);
        cycle(0, 1'b1, 8'h05, 1'b0);
        // pop while full (no pass-through), then the held word wraps to address 0
        cycle(0, 1'b1, 8'h05, 1'b1);
        cycle(0, 1'b1, 8'h05, 1'b0);
        for (int i = 0; i < 4; i++) cycle(0, 1'b0, 8'h00, 1'b1);
        cycle(0, 1'b0, 8'h00, 1'b0);

        // steady state at two entries with push and pop every cycle
        cycle(0, 1'b1, 8'h10, 1'b0);
        cycle(0, 1'b1, 8'h11, 1'b0);
        for (int i = 0; i < 10; i++) cycle(0, 1'b1, 8'(8'h12 + i), 1'b1);
        cycle(0, 1'b0, 8'h00, 1'b1);
        cycle(0, 1'b0, 8'h00, 1'b1);
        cycle(0, 1'b0, 8'h00, 1'b0);

        // random traffic on the depth-4 instance
        for (int i = 0; i < 300; i++)
            cycle(0, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));

        // depth 5: fill, alternate pop/push, then random traffic
        for (int i = 0; i < 5; i++) cycle(1, 1'b1, 8'(8'h40 + i), 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) cycle(1, 1'b0, 8'h00, 1'b1);
            else            cycle(1, 1'b1, 8'(8'h60 + i), 1'b0);
        end
        for (int i = 0; i < 200; i++)
            cycle(1, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));

        // asynchronous reset mid-cycle with three entries held
        do_reset();
        for (int i = 0; i < 3; i++) cycle(0, 1'b1, 8'(8'hC0 + i), 1'b0);
        cycle(0, 1'b0, 8'h00, 1'b0);
        @(posedge clk);
        #2;
        do_reset();
        cycle(0, 1'b1, 8'h5A, 1'b0);
        cycle(0, 1'b1, 8'h5B, 1'b1);
        cycle(0, 1'b0, 8'h00, 1'b1);
        cycle(0, 1'b0, 8'h00, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
